// File: rtl/reg_hazard_scheduler.sv
// Read-after-write hazard scheduler: four-slot destination tracker (Execute..Writeback),
// issue gating and a saturating stall counter. Define SCOREBOARD_FWD_EN to exclude S4 from matching.
module reg_hazard_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [2:0]  issue_rs1,
    input  logic [2:0]  issue_rs2,
    input  logic [1:0]  issue_rs_use,
    input  logic [2:0]  issue_rd,
    input  logic        issue_rd_we,
    input  logic        flush,
    input  logic        hold,
    output logic        issue_ready,
    output logic        hazard,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [2:0]  inflight_cnt,
    output logic [15:0] stall_cnt
);

    // Bit i of the mask selects slot S(i+1) for source matching.
`ifdef SCOREBOARD_FWD_EN
    localparam logic [3:0] MATCH_MASK = 4'b0111;
`else
    localparam logic [3:0] MATCH_MASK = 4'b1111;
`endif

    logic [3:0]       r_slot_vld;
    logic [3:0][2:0]  r_slot_rd;
    logic [15:0]      r_stall_cnt;

    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_hazard;
    logic             w_ready;
    logic             w_stall_inc;
    logic             w_s1_vld;
    logic [2:0]       w_s1_rd;
    logic [2:0]       w_inflight;

    // Source-versus-tracker comparison and issue gating.
    always_comb begin
        w_rs1_hit = 1'b0;
        w_rs2_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_rs1_hit = w_rs1_hit | (MATCH_MASK[i] & r_slot_vld[i] & issue_rs_use[0]
                                     & (r_slot_rd[i] == issue_rs1));
            w_rs2_hit = w_rs2_hit | (MATCH_MASK[i] & r_slot_vld[i] & issue_rs_use[1]
                                     & (r_slot_rd[i] == issue_rs2));
        end
        w_hazard    = issue_valid & (w_rs1_hit | w_rs2_hit);
        w_ready     = issue_valid & ~w_hazard & ~hold & ~flush;
        w_stall_inc = w_hazard & ~hold & ~flush;
        w_s1_vld    = w_ready & issue_rd_we;
        w_s1_rd     = w_s1_vld ? issue_rd : 3'd0;
    end

    // Occupancy popcount across all four slots, S4 included.
    always_comb begin
        w_inflight = {2'b00, r_slot_vld[0]} + {2'b00, r_slot_vld[1]}
                   + {2'b00, r_slot_vld[2]} + {2'b00, r_slot_vld[3]};
    end

    // Tracker pipeline: shifts toward S4 unless held; S1 takes the accepted write or a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_vld <= 4'b0000;
            r_slot_rd  <= 12'h000;
        end else if (!hold) begin
            r_slot_vld <= {r_slot_vld[2:0], w_s1_vld};
            r_slot_rd  <= {r_slot_rd[2:0], w_s1_rd};
        end else begin
            r_slot_vld <= r_slot_vld;
            r_slot_rd  <= r_slot_rd;
        end
    end

    // Saturating count of cycles lost to a genuine hazard stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign hazard       = w_hazard;
    assign issue_ready  = w_ready;
    assign wb_valid     = r_slot_vld[3];
    assign wb_rd        = r_slot_rd[3];
    assign inflight_cnt = w_inflight;
    assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_reg_hazard_scheduler.sv
// Directed self-checking bench for reg_hazard_scheduler; expectations follow SCOREBOARD_FWD_EN.
module tb_reg_hazard_scheduler;

`ifdef SCOREBOARD_FWD_EN
    localparam int LAT     = 3;
    localparam int PERIODS = 21860;
`else
    localparam int LAT     = 4;
    localparam int PERIODS = 16400;
`endif

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic [2:0]  issue_rs1;
    logic [2:0]  issue_rs2;
    logic [1:0]  issue_rs_use;
    logic [2:0]  issue_rd;
    logic        issue_rd_we;
    logic        flush;
    logic        hold;
    logic        issue_ready;
    logic        hazard;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [2:0]  inflight_cnt;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    reg_hazard_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rs_use (issue_rs_use),
        .issue_rd     (issue_rd),
        .issue_rd_we  (issue_rd_we),
        .flush        (flush),
        .hold         (hold),
        .issue_ready  (issue_ready),
        .hazard       (hazard),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .inflight_cnt (inflight_cnt),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [1:0] use_b, input logic [2:0] rd, input logic we);
        issue_valid  = v;
        issue_rs1    = rs1;
        issue_rs2    = rs2;
        issue_rs_use = use_b;
        issue_rd     = rd;
        issue_rd_we  = we;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        hold  = 1'b0;
        drv(1'b1, 3'd0, 3'd0, 2'b01, 3'd0, 1'b0);
        step();
        check_val("rst_inflight", inflight_cnt, 0);
        check_val("rst_wb_valid", wb_valid, 0);
        check_val("rst_wb_rd", wb_rd, 0);
        check_val("rst_stall", stall_cnt, 0);
        check_val("rst_hazard", hazard, 0);
        check_val("rst_ready", issue_ready, 1);
        step();
        reset = 1'b0;

        // RAW on rd=3, reader one cycle behind
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1);
        check_val("w3_ready", issue_ready, 1);
        step();
        check_val("w3_inflight", inflight_cnt, 1);
        drv(1'b1, 3'd3, 3'd0, 2'b01, 3'd0, 1'b0);
        for (int k = 0; k < LAT; k++) begin
            check_val("raw_hazard", hazard, 1);
            check_val("raw_ready", issue_ready, 0);
            step();
            if (k == 2) begin
                check_val("raw_wb_valid", wb_valid, 1);
                check_val("raw_wb_rd", wb_rd, 3);
            end
        end
        check_val("raw_clear_hazard", hazard, 0);
        check_val("raw_clear_ready", issue_ready, 1);
        check_val("raw_stall_cnt", stall_cnt, LAT);
        step();

        // Independent write then read, writeback latency
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1);
        step();
        drv(1'b1, 3'd2, 3'd0, 2'b01, 3'd0, 1'b0);
        check_val("indep_hazard", hazard, 0);
        check_val("indep_ready", issue_ready, 1);
        step();
        idle();
        step();
        check_val("wb5_early", wb_valid, 0);
        step();
        check_val("wb5_valid", wb_valid, 1);
        check_val("wb5_rd", wb_rd, 5);
        check_val("wb5_inflight", inflight_cnt, 1);

        // Hold freezes tracker and takes priority over a new issue
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd4, 1'b1);
        step();
        hold = 1'b1;
        drv(1'b1, 3'd4, 3'd0, 2'b01, 3'd7, 1'b1);
        check_val("hold_hazard", hazard, 1);
        check_val("hold_ready", issue_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("hold_inflight", inflight_cnt, 1);
            check_val("hold_stall", stall_cnt, LAT);
            check_val("hold_wb_valid", wb_valid, 0);
        end
        hold = 1'b0;
        idle();
        step();
        step();
        check_val("post_hold_early", wb_valid, 0);
        step();
        check_val("post_hold_wb_valid", wb_valid, 1);
        check_val("post_hold_wb_rd", wb_rd, 4);

        // Flush blocks the issue, does not count a stall, tracker keeps draining
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd1, 1'b1);
        step();
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd2, 1'b1);
        step();
        check_val("pre_flush_inflight", inflight_cnt, 2);
        flush = 1'b1;
        drv(1'b1, 3'd2, 3'd0, 2'b01, 3'd6, 1'b1);
        check_val("flush_hazard", hazard, 1);
        check_val("flush_ready", issue_ready, 0);
        step();
        flush = 1'b0;
        idle();
        check_val("flush_stall", stall_cnt, LAT);
        check_val("flush_inflight", inflight_cnt, 2);
        step();
        check_val("flush_wb1", wb_rd, 1);
        check_val("flush_inflight2", inflight_cnt, 2);
        step();
        check_val("flush_wb2", wb_rd, 2);
        check_val("flush_inflight1", inflight_cnt, 1);
        step();
        check_val("flush_no_rd6", wb_valid, 0);
        check_val("flush_inflight0", inflight_cnt, 0);

        // Address 0 twice in flight; rs_use gating
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd0, 1'b1);
        step();
        step();
        check_val("r0_inflight", inflight_cnt, 2);
        drv(1'b1, 3'd5, 3'd0, 2'b10, 3'd0, 1'b0);
        check_val("r0_rs2_hazard", hazard, 1);
        drv(1'b1, 3'd0, 3'd1, 2'b10, 3'd0, 1'b0);
        check_val("r0_use_gate", hazard, 0);
        check_val("r0_use_ready", issue_ready, 1);
        idle();
        repeat (4) step();
        check_val("r0_drained", inflight_cnt, 0);

        // Reset mid-stall with three writes in flight
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1);
        step();
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd4, 1'b1);
        step();
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd5, 1'b1);
        step();
        check_val("mid_inflight", inflight_cnt, 3);
        drv(1'b1, 3'd5, 3'd0, 2'b01, 3'd0, 1'b0);
        check_val("mid_hazard", hazard, 1);
        step();
        check_val("mid_stall", stall_cnt, LAT + 1);
        check_val("mid_wb_valid", wb_valid, 1);
        reset = 1'b1;
        #1;
        check_val("arst_inflight", inflight_cnt, 0);
        check_val("arst_wb_valid", wb_valid, 0);
        check_val("arst_wb_rd", wb_rd, 0);
        check_val("arst_stall", stall_cnt, 0);
        check_val("arst_hazard", hazard, 0);
        check_val("arst_ready", issue_ready, 1);
        step();
        reset = 1'b0;
        #1;
        check_val("rel_ready", issue_ready, 1);
        step();
        check_val("rel_inflight", inflight_cnt, 0);
        check_val("rel_stall", stall_cnt, 0);

        // Sustained hazard stalls until saturation
        for (int p = 0; p < PERIODS; p++) begin
            drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1);
            step();
            drv(1'b1, 3'd3, 3'd0, 2'b01, 3'd0, 1'b0);
            repeat (LAT) step();
            if (p == 999) begin
                check_val("sat_midway", stall_cnt, LAT * 1000);
            end
        end
        check_val("sat_ffff", stall_cnt, 16'hFFFF);
        drv(1'b1, 3'd0, 3'd0, 2'b00, 3'd3, 1'b1);
        step();
        drv(1'b1, 3'd3, 3'd0, 2'b01, 3'd0, 1'b0);
        step();
        check_val("sat_hold", stall_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_hazard_scheduler.md
REG_HAZARD_SCHEDULER -- requirements
Module: reg_hazard_scheduler

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; all state SHALL use clk and reset.
REQ-002 The ports SHALL be exactly as listed below.
  - clk  input  1  rising-edge clock.
  - reset  input  1  asynchronous, active-high.
  - issue_valid  input  1  Register_Read stage holds an instruction.
  - issue_rs1  input  3  first source register address.
  - issue_rs2  input  3  second source register address.
  - issue_rs_use  input  2  bit0 = rs1 read, bit1 = rs2 read.
  - issue_rd  input  3  destination register address.
  - issue_rd_we  input  1  instruction writes issue_rd.
  - flush  input  1  branch squash; the current issue is discarded.
  - hold  input  1  downstream pipeline stall.
  - issue_ready  output  1  instruction accepted this cycle.
  - hazard  output  1  read-after-write conflict detected.
  - wb_valid  output  1  tracker slot S4 valid (write retiring).
  - wb_rd  output  3  tracker slot S4 destination.
  - inflight_cnt  output  3  number of valid slots S1..S4 (0..4).
  - stall_cnt  output  16  saturating count of hazard-stall cycles.

Function
REQ-003 The block SHALL hold a 4-slot tracker S1..S4 (Execute, Mem-Addr, Mem, Writeback); each slot holds {valid, rd[2:0]}.
REQ-004 A source SHALL match when its issue_rs_use bit is 1, a checked slot is valid, and the slot rd equals that source address.
REQ-005 hazard SHALL be combinational and equal issue_valid AND (any rs1 or rs2 match).
REQ-006 issue_ready SHALL equal issue_valid AND NOT hazard AND NOT hold AND NOT flush.
REQ-007 An issue SHALL be accepted on a rising edge when issue_ready=1.
REQ-008 On an edge with hold=0, the tracker SHALL shift: S4<=S3, S3<=S2, S2<=S1.
REQ-009 On the same edge, S1 SHALL load {1, issue_rd} if an accepted issue has issue_rd_we=1; otherwise S1 SHALL load a bubble (valid=0).
REQ-010 On an edge with hold=1, all slots SHALL keep their values; hold SHALL take priority over both shifting and accepting an issue.
REQ-011 flush SHALL only block the current issue; tracker slots SHALL NOT be cleared by flush, and shifting SHALL continue if hold=0.
REQ-012 wb_valid and wb_rd SHALL be driven directly from slot S4; a write enters S4 exactly 4 non-hold edges after acceptance.
REQ-013 inflight_cnt SHALL be the combinational popcount of the valid bits of S1..S4.
REQ-014 stall_cnt SHALL increment on each edge where hazard=1, hold=0 and flush=0.
REQ-015 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-016 With issue_rd_we=0, an accepted instruction SHALL create no tracker entry.
REQ-017 Two valid slots holding the same rd SHALL each raise a match independently.
REQ-018 All 8 register addresses, including address 0, SHALL be treated as writable.

Reset
REQ-019 While reset=1, all slot valid bits, slot rd fields and stall_cnt SHALL be 0 asynchronously.
REQ-020 During reset, wb_valid=0, wb_rd=0 and inflight_cnt=0.
REQ-021 During reset, issue_ready and hazard SHALL follow REQ-005/REQ-006 against the empty tracker.
REQ-022 Reset asserted mid-stall SHALL discard all in-flight tracking; the first edge after release SHALL behave as on an empty tracker.

Configuration
REQ-023 When SCOREBOARD_FWD_EN is defined, slot S4 SHALL be excluded from matching, because the register file is write-first and bypasses the retiring write; the matched slots are S1..S3.
REQ-024 When SCOREBOARD_FWD_EN is undefined, slots S1..S4 SHALL all be matched.
REQ-025 In both configurations, wb_valid, wb_rd and inflight_cnt SHALL include slot S4.

Verification
REQ-026 Reset, then issue rd=3 (we=1), then issue rs1=3 (use=01) the next cycle -> hazard=1 and issue_ready=0 for 3 cycles with FWD_EN defined, 4 without; stall_cnt=3 or 4 respectively.
REQ-027 Issue rd=5 (we=1), then next cycle issue rs1=2 (use=01) -> no hazard, issue_ready=1; wb_valid=1 with wb_rd=5 on the 4th edge after the first issue.
REQ-028 Tracker S1=rd 4, then hold=1 for 3 cycles -> slots frozen, inflight_cnt stays 1, stall_cnt unchanged while hold=1.
REQ-029 flush=1 with issue_valid=1, rd=6, we=1 -> issue_ready=0, S1 loads a bubble, inflight_cnt drops as older slots retire.
REQ-030 Force continuous hazard for 65540 cycles -> stall_cnt holds at 16'hFFFF.
REQ-031 Reset asserted while inflight_cnt=3 -> immediately inflight_cnt=0, wb_valid=0, stall_cnt=0; after release a previously conflicting read issues with issue_ready=1.
